uart_tx_queue: RTL

- Transmit-side byte queue that sits directly upstream of the UART core transmitter.
- Buffers host-written bytes in a small FIFO and drives the core's tx_data/tx_start pair.
- Paces each start on the core's registered tx_busy, which lags tx_start by two cycles, so no byte is lost or sent twice.
- Provides level, full/empty, sticky overflow, pause and flush to the host side.

---
 rtl/uart_tx_queue_if.sv | 36 +++
 rtl/uart_tx_queue.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue_if.sv
// ---------------------------------------------------------------------------
// uart_tx_queue_if
// Bundles the signals of uart_tx_queue: the host side (writes, flush, pause,
// status) and the core side (tx_start/tx_data out, tx_busy in).
//   slave  : view used by the queue itself
//   master : view used by whatever drives the queue (host + core model)
// Parameter ADDR_W must match the queue's ADDR_W; level is ADDR_W+1 bits.
// ---------------------------------------------------------------------------
interface uart_tx_queue_if #(
    parameter int ADDR_W = 3
);
    // host side
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              flush;
    logic              en;
    logic              clr_overflow;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    // core side
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;

    modport slave (
        input  wr_en, wr_data, flush, en, clr_overflow, tx_busy,
        output full, empty, level, overflow, tx_start, tx_data
    );

    modport master (
        output wr_en, wr_data, flush, en, clr_overflow, tx_busy,
        input  full, empty, level, overflow, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
// Transmit byte queue placed directly in front of the UART core transmitter.
// Host bytes are buffered in a circular FIFO; a small FSM pops one byte at a
// time into tx_data and pulses tx_start, then waits for the core's registered
// tx_busy to rise and fall before the next pop.
//
// Ports:
//   clk    : clock, all logic on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_tx_queue_if.slave
//            in : wr_en, wr_data, flush, en, clr_overflow, tx_busy
//            out: tx_start, tx_data, full, empty, level, overflow
// Parameters:
//   DEPTH  : FIFO entries, power of two, 2..64
//   ADDR_W : log2(DEPTH)
// ---------------------------------------------------------------------------
module uart_tx_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_queue_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    state_t            r_state;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_wr_drop;
    logic w_pop;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // Acceptance looks only at the pre-edge count: a pop in the same cycle
    // never makes room for a write to a full queue.
    assign w_wr_accept = bus.wr_en && !w_full && !bus.flush;
    // Flush discards a same-cycle write silently, so it is not an overflow.
    assign w_wr_drop   = bus.wr_en &&  w_full && !bus.flush;
    // Flush also suppresses a pop that would otherwise happen this cycle.
    assign w_pop       = (r_state == IDLE) && bus.en && !w_empty && !bus.flush;

    // NOTE: the storage array has no reset; every entry is written before it
    // can be read, and leaving it out keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // block sees the pre-edge value of every register regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr_accept && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_wr_accept && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Start pacing. tx_busy is registered inside the core and rises two
    // cycles after tx_start, so the FSM must see busy high and then low
    // before it may pop again; otherwise a start could be lost or doubled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_tx_start <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_count;
    assign bus.overflow = r_overflow;

endmodule
